// File: rtl/uart_tx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_ctrl_pkg
// Purpose : Shared UART TX definitions: FSM encodings and frame constants
// Rev     : 1.0  initial release
// ============================================================================
package uart_tx_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_DATA  = 2'd2;
    localparam state_t ST_STOP  = 2'd3;

    localparam int unsigned DEFAULT_BIT_PERIOD = 10417;
    localparam int unsigned FRAME_BITS         = 10;
    localparam int unsigned DATA_BITS          = 8;

    // A one-cycle bit period still needs a 1-bit timer to stay legal.
    function automatic int unsigned timer_width(input int unsigned period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_ctrl_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module  : byte_fifo
// Purpose : Byte-wide FIFO, depth 2**FIFO_AW; push at full is rejected
// Rev     : 1.0  initial release
// ============================================================================
module byte_fifo
    import uart_tx_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_AW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 pop_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [FIFO_AW:0]     count_o
);

    localparam int unsigned        C_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   C_FULL  = (FIFO_AW + 1)'(C_DEPTH);

    logic [DATA_BITS-1:0] mem_q [C_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 w_push;
    logic                 w_pop;

    // Full/empty come from the registered count, so a same-edge pop never frees room for a push.
    assign full_o  = (count_q == C_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_ctrl
// Purpose : FIFO-buffered 8N1 UART transmitter, LSB first, registered TX
// Rev     : 1.0  initial release
// ============================================================================
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int unsigned BIT_PERIOD = DEFAULT_BIT_PERIOD,
    parameter int unsigned FIFO_AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 drop_o,
    output logic                 tx_o
);

    localparam int unsigned      C_TW    = timer_width(BIT_PERIOD);
    localparam logic [C_TW-1:0]  C_TMAX  = C_TW'(BIT_PERIOD - 1);
    localparam int unsigned      C_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] C_FULL  = (FIFO_AW + 1)'(C_DEPTH);

    state_t               state_q, state_d;
    logic [C_TW-1:0]      timer_q, timer_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 drop_q, drop_d;

    logic [DATA_BITS-1:0] w_fifo_data;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [FIFO_AW:0]     w_fifo_count;
    logic                 w_pop;
    logic                 w_bit_end;

    byte_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (valid_i),
        .data_i  (data_i),
        .pop_i   (w_pop),
        .data_o  (w_fifo_data),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    assign w_bit_end = (timer_q == C_TMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        w_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop     = 1'b1;
                    shift_d   = w_fifo_data;
                    bit_idx_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // A queued byte chains straight into its start bit with no idle cycle.
                if (w_bit_end) begin
                    if (!w_fifo_empty) begin
                        w_pop     = 1'b1;
                        shift_d   = w_fifo_data;
                        bit_idx_d = '0;
                        state_d   = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q == ST_IDLE) || (state_d != state_q) || w_bit_end) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // TX is decoded from the next state so the line changes on the edge that enters it.
    always_comb begin
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
        drop_d = valid_i & w_fifo_full;
    end

    assign tx_o    = tx_q;
    assign drop_o  = drop_q;
    assign ready_o = (w_fifo_count != C_FULL);
    assign busy_o  = (state_q != ST_IDLE) | (w_fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_ctrl
// Purpose : Directed self-checking bench for uart_tx_ctrl (BIT_PERIOD=16)
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_tx_ctrl;

    localparam int BP = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic       busy_o;
    logic       drop_o;
    logic       tx_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int drop_cnt = 0;
    int drop_base;

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .BIT_PERIOD (BP),
        .FIFO_AW    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .drop_o  (drop_o),
        .tx_o    (tx_o)
    );

    always @(negedge clk) begin
        if (drop_o === 1'b1) drop_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_window(input string tag, input int n);
        int bad = 0;
        repeat (n) begin
            tick(1);
            if (tx_o !== 1'b1 || busy_o !== 1'b0 || drop_o !== 1'b0 || ready_o !== 1'b1) bad++;
        end
        check(tag, bad, 0);
    endtask

    // Entered `already` cycles after the edge where the start bit began; returns at the next frame boundary.
    task automatic expect_frame(input string tag, input int already, input logic [7:0] exp,
                                input bit last, input bit inj, input logic [7:0] inj_data);
        logic [7:0] b;
        logic       start_bit, stop_bit, busy_late;
        tick(8 - already);
        start_bit = tx_o;
        for (int k = 0; k < 8; k++) begin
            tick(BP);
            b[k] = tx_o;
        end
        tick(BP);
        stop_bit = tx_o;
        tick(7);
        busy_late = busy_o;
        if (inj) begin
            valid_i = 1'b1;
            data_i  = inj_data;
        end
        tick(1);
        valid_i = 1'b0;
        check($sformatf("%s_start", tag), start_bit, 0);
        check($sformatf("%s_data", tag), b, exp);
        check($sformatf("%s_stop", tag), stop_bit, 1);
        check($sformatf("%s_busy_last_cycle", tag), busy_late, 1);
        if (last) begin
            check($sformatf("%s_busy_after", tag), busy_o, 0);
            check($sformatf("%s_tx_idle_after", tag), tx_o, 1);
        end else begin
            check($sformatf("%s_no_gap", tag), tx_o, 0);
        end
    endtask

    initial begin
        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx_o, 1);
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_drop", drop_o, 0);
        rst = 1'b0;
        idle_window("idle100", 100);

        // Single byte: latency and bit order
        valid_i = 1'b1;
        data_i  = 8'hA5;
        tick(1);
        valid_i = 1'b0;
        check("a5_tx_e0", tx_o, 1);
        check("a5_busy_e0", busy_o, 1);
        tick(1);
        check("a5_tx_e1", tx_o, 0);
        expect_frame("a5", 0, 8'hA5, 1'b1, 1'b0, 8'h00);
        idle_window("idle_after_a5", 10);

        // Five strobes fill the FIFO without a drop
        drop_base = drop_cnt;
        valid_i = 1'b1;
        data_i  = 8'h01; tick(1);
        data_i  = 8'h02; tick(1);
        check("burst5_tx_e1", tx_o, 0);
        data_i  = 8'h03; tick(1);
        data_i  = 8'h04; tick(1);
        data_i  = 8'h05; tick(1);
        valid_i = 1'b0;
        check("burst5_ready_full", ready_o, 0);
        check("burst5_drop", drop_o, 0);
        expect_frame("b01", 3, 8'h01, 1'b0, 1'b0, 8'h00);
        expect_frame("b02", 0, 8'h02, 1'b0, 1'b0, 8'h00);
        expect_frame("b03", 0, 8'h03, 1'b0, 1'b0, 8'h00);
        expect_frame("b04", 0, 8'h04, 1'b0, 1'b0, 8'h00);
        expect_frame("b05", 0, 8'h05, 1'b1, 1'b0, 8'h00);
        check("burst5_drop_count", drop_cnt - drop_base, 0);
        tick(5);

        // Six strobes: the sixth is dropped
        drop_base = drop_cnt;
        valid_i = 1'b1;
        data_i  = 8'h10; tick(1);
        data_i  = 8'h11; tick(1);
        data_i  = 8'h12; tick(1);
        data_i  = 8'h13; tick(1);
        data_i  = 8'h14; tick(1);
        data_i  = 8'h15; tick(1);
        valid_i = 1'b0;
        check("burst6_drop_pulse", drop_o, 1);
        tick(1);
        check("burst6_drop_clear", drop_o, 0);
        expect_frame("c10", 5, 8'h10, 1'b0, 1'b0, 8'h00);
        expect_frame("c11", 0, 8'h11, 1'b0, 1'b0, 8'h00);
        expect_frame("c12", 0, 8'h12, 1'b0, 1'b0, 8'h00);
        expect_frame("c13", 0, 8'h13, 1'b0, 1'b0, 8'h00);
        expect_frame("c14", 0, 8'h14, 1'b1, 1'b0, 8'h00);
        check("burst6_drop_count", drop_cnt - drop_base, 1);
        tick(5);

        // Push coinciding with the STOP-to-START pop at count=2
        valid_i = 1'b1;
        data_i  = 8'h81; tick(1);
        data_i  = 8'h42; tick(1);
        data_i  = 8'hC3; tick(1);
        valid_i = 1'b0;
        expect_frame("d81", 1, 8'h81, 1'b0, 1'b1, 8'h3C);
        check("pushpop_ready", ready_o, 1);
        expect_frame("d42", 0, 8'h42, 1'b0, 1'b0, 8'h00);
        expect_frame("dC3", 0, 8'hC3, 1'b0, 1'b0, 8'h00);
        expect_frame("d3C", 0, 8'h3C, 1'b1, 1'b0, 8'h00);
        tick(5);

        // Consecutive rejected strobes, then async reset during a start bit
        valid_i = 1'b1;
        data_i  = 8'h20; tick(1);
        data_i  = 8'h21; tick(1);
        data_i  = 8'h22; tick(1);
        data_i  = 8'h23; tick(1);
        data_i  = 8'h24; tick(1);
        data_i  = 8'h25; tick(1);
        check("drop2_first", drop_o, 1);
        data_i  = 8'h26; tick(1);
        valid_i = 1'b0;
        check("drop2_second", drop_o, 1);
        tick(1);
        check("drop2_clear", drop_o, 0);
        check("rst_start_tx_low", tx_o, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_tx", tx_o, 1);
        check("rst_async_busy", busy_o, 0);
        tick(2);
        rst = 1'b0;
        idle_window("idle_after_rst1", 50);

        // Reset during data bit 4 of 8'hFF with two bytes queued
        valid_i = 1'b1;
        data_i  = 8'hFF; tick(1);
        data_i  = 8'h11; tick(1);
        data_i  = 8'h22; tick(1);
        valid_i = 1'b0;
        tick(87);
        check("ff_bit4_tx", tx_o, 1);
        check("ff_bit4_busy", busy_o, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_tx", tx_o, 1);
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_ready", ready_o, 1);
        tick(2);
        rst = 1'b0;
        idle_window("idle_after_rst2", 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
